// File: rtl/comp_checker.sv
// Session-based checker for a 4-bit magnitude comparator: counts mismatching
// samples, tracks pair coverage over all 256 operand pairs, and ends on full coverage or idle timeout.
module comp_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sample_valid,
  input  logic [3:0] in_1,
  input  logic [3:0] in_2,
  input  logic       great,
  input  logic       equal,
  input  logic       less,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] err_count,
  output logic [3:0] first_err_in1,
  output logic [3:0] first_err_in2,
  output logic [8:0] cover_count,
  output logic [1:0] state_dbg
);

  // Handshake: a sample is taken on every rising edge where sample_valid=1
  // while in RUN; there is no ready, the checker never stalls the source.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     err_count_q, err_count_d;
  logic [3:0]     first_in1_q, first_in1_d;
  logic [3:0]     first_in2_q, first_in2_d;
  logic [8:0]     cover_count_q, cover_count_d;
  logic [255:0]   cover_map_q, cover_map_d;
  logic [15:0]    idle_q, idle_d;
  logic           timeout_q, timeout_d;

  logic           exp_great, exp_equal, exp_less;
  logic           mismatch;
  logic [7:0]     pair_idx;
  logic [16:0]    idle_inc;
  logic           clear_session;

  assign exp_great = (in_1 > in_2);
  assign exp_equal = (in_1 == in_2);
  assign exp_less  = (in_1 < in_2);
  assign mismatch  = ({great, equal, less} != {exp_great, exp_equal, exp_less});
  assign pair_idx  = {in_1, in_2};
  assign idle_inc  = {1'b0, idle_q} + 17'd1;

  always_comb begin
    state_d       = state_q;
    err_count_d   = err_count_q;
    first_in1_d   = first_in1_q;
    first_in2_d   = first_in2_q;
    cover_count_d = cover_count_q;
    cover_map_d   = cover_map_q;
    idle_d        = idle_q;
    timeout_d     = timeout_q;
    clear_session = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) clear_session = 1'b1;
      end
      S_RUN: begin
        if (sample_valid) begin
          idle_d = '0;
          if (mismatch) begin
            err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
            // err_count is still zero only until the first mismatch lands
            if (err_count_q == 8'd0) begin
              first_in1_d = in_1;
              first_in2_d = in_2;
            end
          end
          if (!cover_map_q[pair_idx]) begin
            cover_map_d[pair_idx] = 1'b1;
            cover_count_d         = cover_count_q + 9'd1;
            if (cover_count_q == 9'd255) state_d = S_DONE;
          end
        end else begin
          idle_d = idle_inc[15:0];
          if (idle_inc == 17'(TIMEOUT_CYCLES)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (start) clear_session = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_session) begin
      state_d       = S_RUN;
      err_count_d   = '0;
      first_in1_d   = '0;
      first_in2_d   = '0;
      cover_count_d = '0;
      cover_map_d   = '0;
      idle_d        = '0;
      timeout_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      err_count_q   <= '0;
      first_in1_q   <= '0;
      first_in2_q   <= '0;
      cover_count_q <= '0;
      cover_map_q   <= '0;
      idle_q        <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_count_q   <= err_count_d;
      first_in1_q   <= first_in1_d;
      first_in2_q   <= first_in2_d;
      cover_count_q <= cover_count_d;
      cover_map_q   <= cover_map_d;
      idle_q        <= idle_d;
      timeout_q     <= timeout_d;
    end
  end

  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_count_q == 8'd0) && !timeout_q;
  assign timeout       = timeout_q;
  assign err_count     = err_count_q;
  assign first_err_in1 = first_in1_q;
  assign first_err_in2 = first_in2_q;
  assign cover_count   = cover_count_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_comp_checker.sv
// Directed bench for comp_checker: a vector table for single-sample checks plus
// hand-written sessions for sweeps, saturation, timeout and mid-session reset.
module tb_comp_checker;

  localparam int unsigned TO = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sample_valid;
  logic [3:0] in_1, in_2;
  logic       great, equal, less;
  logic       busy, done, pass, timeout;
  logic [7:0] err_count;
  logic [3:0] first_err_in1, first_err_in2;
  logic [8:0] cover_count;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  comp_checker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .in_1(in_1), .in_2(in_2), .great(great), .equal(equal), .less(less),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_in1(first_err_in1),
    .first_err_in2(first_err_in2), .cover_count(cover_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       g;
    logic       e;
    logic       l;
    int         exp_err;
    int         exp_cov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock cycle of stimulus; outputs are sampled 1 ns after the edge
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic g, input logic e, input logic l, input logic st);
    sample_valid = v;
    in_1  = a;
    in_2  = b;
    great = g;
    equal = e;
    less  = l;
    start = st;
    @(posedge clk);
    #1;
    start        = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic begin_session();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("session_busy", busy, 1);
    chk("session_err_clr", err_count, 0);
    chk("session_cov_clr", cover_count, 0);
    chk("session_to_clr", timeout, 0);
  endtask

  // mode 0: correct comparator, 1: great dropped at (5,3), 2: all outputs high
  task automatic sweep(input int mode, input int n);
    logic [3:0] a, b;
    logic g, e, l;
    for (int i = 0; i < n; i++) begin
      a = 4'(i / 16);
      b = 4'(i % 16);
      g = (a > b);
      e = (a == b);
      l = (a < b);
      if (mode == 1 && a == 4'd5 && b == 4'd3) g = 1'b0;
      if (mode == 2) begin
        g = 1'b1; e = 1'b1; l = 1'b1;
      end
      drive(1'b1, a, b, g, e, l, 1'b0);
      if (i == 254) chk("sweep_done_early", done, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sample_valid = 1'b0;
    in_1 = '0; in_2 = '0;
    great = 1'b0; equal = 1'b0; less = 1'b0;

    vecs[0] = '{4'd5,  4'd3,  1'b1, 1'b0, 1'b0, 0, 1};
    vecs[1] = '{4'd3,  4'd5,  1'b0, 1'b0, 1'b1, 0, 2};
    vecs[2] = '{4'd7,  4'd7,  1'b0, 1'b1, 1'b0, 0, 3};
    vecs[3] = '{4'd5,  4'd3,  1'b1, 1'b0, 1'b0, 0, 3};
    vecs[4] = '{4'd2,  4'd9,  1'b0, 1'b0, 1'b0, 1, 4};
    vecs[5] = '{4'd9,  4'd2,  1'b1, 1'b1, 1'b0, 2, 5};
    vecs[6] = '{4'd9,  4'd2,  1'b0, 1'b0, 1'b1, 3, 5};
    vecs[7] = '{4'd15, 4'd0,  1'b1, 1'b0, 1'b0, 3, 6};
    vecs[8] = '{4'd0,  4'd15, 1'b0, 1'b0, 1'b1, 3, 7};
    vecs[9] = '{4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 3, 8};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first1", first_err_in1, 0);
    chk("rst_first2", first_err_in2, 0);
    chk("rst_cover", cover_count, 0);
    rst_n = 1'b1;
    idle_cycles(2);
    chk("idle_wait", busy, 0);

    // start together with a bad sample in IDLE: sample must be dropped
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("idle_sample_busy", busy, 1);
    chk("idle_sample_err", err_count, 0);
    chk("idle_sample_cov", cover_count, 0);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].e, vecs[i].l, 1'b0);
      chk($sformatf("vec%0d_err", i), err_count, vecs[i].exp_err);
      chk($sformatf("vec%0d_cov", i), cover_count, vecs[i].exp_cov);
    end
    chk("vec_first1", first_err_in1, 2);
    chk("vec_first2", first_err_in2, 9);

    // start in RUN is ignored and counts as an idle cycle
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("run_start_cov", cover_count, 8);
    chk("run_start_err", err_count, 3);
    idle_cycles(TO - 2);
    chk("to_busy_before", busy, 1);
    chk("to_done_before", done, 0);
    idle_cycles(1);
    chk("to_done", done, 1);
    chk("to_timeout", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_cover", cover_count, 8);

    // samples in DONE are ignored
    drive(1'b1, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_sample_err", err_count, 3);
    chk("done_sample_cov", cover_count, 8);
    chk("done_hold", done, 1);

    begin_session();
    sweep(0, 256);
    chk("good_done", done, 1);
    chk("good_state", state_dbg, 2);
    chk("good_pass", pass, 1);
    chk("good_err", err_count, 0);
    chk("good_cov", cover_count, 256);
    chk("good_to", timeout, 0);

    begin_session();
    sweep(1, 256);
    chk("g53_done", done, 1);
    chk("g53_err", err_count, 1);
    chk("g53_first1", first_err_in1, 5);
    chk("g53_first2", first_err_in2, 3);
    chk("g53_pass", pass, 0);

    begin_session();
    sweep(2, 256);
    chk("sat_done", done, 1);
    chk("sat_err", err_count, 255);
    chk("sat_cov", cover_count, 256);
    chk("sat_pass", pass, 0);
    idle_cycles(2);
    chk("sat_hold", err_count, 255);

    begin_session();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (busy !== 1'b1) chk($sformatf("rep_busy_%0d", i), busy, 1);
    end
    chk("rep_cov", cover_count, 1);
    chk("rep_busy", busy, 1);
    idle_cycles(TO - 1);
    chk("rep_busy_before_to", busy, 1);
    idle_cycles(1);
    chk("rep_done", done, 1);
    chk("rep_to", timeout, 1);
    chk("rep_pass", pass, 0);
    chk("rep_err", err_count, 0);

    // asynchronous reset mid-session, between clock edges
    begin_session();
    sweep(0, 100);
    chk("mid_cov", cover_count, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cov", cover_count, 0);
    chk("arst_err", err_count, 0);
    chk("arst_state", state_dbg, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);
    chk("arst_wait_idle", busy, 0);
    begin_session();
    sweep(0, 256);
    chk("arst_sweep_pass", pass, 1);
    chk("arst_sweep_cov", cover_count, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
